// File: rtl/mem_io_responder_if.sv
// CPU bus, byte-input, byte-output and stop signals of the memory/IO responder.
// The responder takes the slave side; the CPU/environment takes the master side.
interface mem_io_responder_if;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        rdy_out;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_pop;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        prog_done;

   modport slave (
      input  mem_a, mem_wr, cpu_wdata, rx_valid, rx_data, tx_ready,
      output cpu_rdata, rdy_out, rx_pop, tx_valid, tx_data, prog_done
   );

   modport master (
      output mem_a, mem_wr, cpu_wdata, rx_valid, rx_data, tx_ready,
      input  cpu_rdata, rdy_out, rx_pop, tx_valid, tx_data, prog_done
   );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped I/O: input byte port, cycle counter with snapshot,
// transmit FIFO and sticky stop flag. A full transmit FIFO stalls the CPU via rdy_out.
module mem_io_responder #(
   parameter int unsigned RAM_ADDR_W = 17,
   parameter int unsigned TXQ_DEPTH  = 8
) (
   input logic              clk_in,
   input logic              rst_in,
   mem_io_responder_if.slave bus
);
   localparam int unsigned PTR_W     = $clog2(TXQ_DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_W;
   localparam logic [17:0] IO_DATA_A = 18'h30000;
   localparam logic [15:0] IO_CYC_W  = 16'hC001;   // word holding 0x30004-0x30007

   logic [7:0]       ram_q [RAM_BYTES];
   logic [7:0]       txq_q [TXQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      cyc_q, snap_q;
   logic [7:0]       rdata_q;
   logic             rx_pop_q, done_q;

   logic             rdy_c, io_sel_c, wr_c, rd_c, push_c, pop_c, set_done_c;
   logic [17:0]      io_a_c;
   logic [7:0]       push_data_c;
   logic             unused_addr_c;

   assign rdy_c         = (cnt_q != CNT_W'(TXQ_DEPTH));
   assign io_sel_c      = (bus.mem_a[17:16] == 2'b11);
   assign io_a_c        = bus.mem_a[17:0];
   assign wr_c          = rdy_c & bus.mem_wr;
   assign rd_c          = rdy_c & ~bus.mem_wr;
   assign pop_c         = (cnt_q != '0) & bus.tx_ready;
   assign unused_addr_c = ^bus.mem_a[31:18];

   // I/O write decode; writes are dropped once the program has stopped
   always_comb begin
      push_c      = 1'b0;
      push_data_c = 8'h00;
      set_done_c  = 1'b0;
      if (wr_c && io_sel_c && !done_q) begin
         if (io_a_c == IO_DATA_A && bus.cpu_wdata != 8'h00) begin
            push_c      = 1'b1;
            push_data_c = bus.cpu_wdata;
         end else if (io_a_c[17:2] == IO_CYC_W && io_a_c[1:0] == 2'd0) begin
            push_c     = 1'b1;
            set_done_c = 1'b1;
         end
      end
   end

   // Storage arrays carry no reset; a write during reset is suppressed
   always_ff @(posedge clk_in) begin
      if (wr_c && !io_sel_c && !rst_in) begin
         ram_q[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.cpu_wdata;
      end
      if (push_c && !rst_in) begin
         txq_q[wr_ptr_q] <= push_data_c;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rdata_q  <= 8'h00;
         cyc_q    <= 32'd0;
         snap_q   <= 32'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rx_pop_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         cyc_q    <= cyc_q + 32'd1;
         rx_pop_q <= 1'b0;
         if (rd_c) begin
            if (!io_sel_c) begin
               rdata_q <= ram_q[bus.mem_a[RAM_ADDR_W-1:0]];
            end else if (io_a_c == IO_DATA_A) begin
               rdata_q  <= bus.rx_valid ? bus.rx_data : 8'h00;
               rx_pop_q <= bus.rx_valid;
            end else if (io_a_c[17:2] == IO_CYC_W) begin
               // byte 0 takes the live count and freezes it for bytes 1-3
               case (io_a_c[1:0])
                  2'd1:    rdata_q <= snap_q[15:8];
                  2'd2:    rdata_q <= snap_q[23:16];
                  2'd3:    rdata_q <= snap_q[31:24];
                  default: begin
                     rdata_q <= cyc_q[7:0];
                     snap_q  <= cyc_q;
                  end
               endcase
            end else begin
               rdata_q <= 8'h00;
            end
         end
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (set_done_c) done_q <= 1'b1;
      end
   end

   assign bus.cpu_rdata = rdata_q;
   assign bus.rdy_out   = rdy_c;
   assign bus.rx_pop    = rx_pop_q;
   assign bus.tx_valid  = (cnt_q != '0);
   assign bus.tx_data   = txq_q[rd_ptr_q];
   assign bus.prog_done = done_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized checks of mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_io_responder_if bus ();

   mem_io_responder #(.RAM_ADDR_W(17), .TXQ_DEPTH(DEPTH)) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  ram_m [int];
   logic [7:0]  txq_m [$];
   logic [7:0]  emitted [$];
   logic [31:0] cyc_m, snap_m;
   logic [7:0]  exp_rd;
   logic        rd_known, exp_pop, done_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                        input logic rxv, input logic [7:0] rxd, input logic txr);
      bus.mem_a = a; bus.mem_wr = wr; bus.cpu_wdata = wd;
      bus.rx_valid = rxv; bus.rx_data = rxd; bus.tx_ready = txr;
   endtask

   // One clock: drive, check the pre-edge view, advance the model, check the post-edge view
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                       input logic rxv, input logic [7:0] rxd, input logic txr);
      logic        acc, io, push_m;
      logic [17:0] ia;
      logic [16:0] ra;
      logic [7:0]  pd;
      logic [31:0] sh;
      drive(a, wr, wd, rxv, rxd, txr);
      #1;
      chk("rdy_pre", 32'(bus.rdy_out), 32'(txq_m.size() != DEPTH));
      chk("txv_pre", 32'(bus.tx_valid), 32'(txq_m.size() != 0));
      if (txq_m.size() != 0) chk("tx_head", 32'(bus.tx_data), 32'(txq_m[0]));
      if (bus.tx_valid && txr) emitted.push_back(bus.tx_data);
      acc = (txq_m.size() != DEPTH);
      io = (a[17:16] == 2'b11);
      ia = a[17:0];
      ra = a[16:0];
      exp_pop = 1'b0; push_m = 1'b0; pd = 8'h00;
      if (acc && wr && !io) ram_m[int'(ra)] = wd;
      if (acc && wr && io && !done_m) begin
         if (ia == 18'h30000 && wd != 8'h00) begin push_m = 1'b1; pd = wd; end
         else if (ia == 18'h30004) begin push_m = 1'b1; pd = 8'h00; done_m = 1'b1; end
      end
      if (acc && !wr) begin
         rd_known = 1'b1;
         if (!io) begin
            if (ram_m.exists(int'(ra))) exp_rd = ram_m[int'(ra)];
            else rd_known = 1'b0;
         end else if (ia == 18'h30000) begin
            exp_rd = rxv ? rxd : 8'h00;
            exp_pop = rxv;
         end else if (ia == 18'h30004) begin
            snap_m = cyc_m;
            exp_rd = cyc_m[7:0];
         end else if (ia >= 18'h30005 && ia <= 18'h30007) begin
            sh = snap_m >> (8 * int'(ia - 18'h30004));
            exp_rd = sh[7:0];
         end else begin
            exp_rd = 8'h00;
         end
      end
      if (txq_m.size() != 0 && txr) void'(txq_m.pop_front());
      if (push_m) txq_m.push_back(pd);
      cyc_m = cyc_m + 32'd1;
      @(posedge clk); #1;
      if (rd_known) chk("rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
      chk("rx_pop", 32'(bus.rx_pop), 32'(exp_pop));
      chk("prog_done", 32'(bus.prog_done), 32'(done_m));
      chk("txv", 32'(bus.tx_valid), 32'(txq_m.size() != 0));
      chk("rdy", 32'(bus.rdy_out), 32'(txq_m.size() != DEPTH));
      @(negedge clk);
   endtask

   task automatic idle(input logic txr);
      step(32'h0003_000C, 1'b0, 8'h00, 1'b0, 8'h00, txr);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'h0);
      chk({tag, "_txv"},   32'(bus.tx_valid),  32'h0);
      chk({tag, "_rdy"},   32'(bus.rdy_out),   32'h1);
      chk({tag, "_rxpop"}, 32'(bus.rx_pop),    32'h0);
      chk({tag, "_done"},  32'(bus.prog_done), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(32'h0003_000C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      txq_m.delete();
      cyc_m = 32'd0; snap_m = 32'd0; exp_rd = 8'h00;
      rd_known = 1'b1; done_m = 1'b0; exp_pop = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  wd;
      int          r;
      drive(32'h0003_000C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      do_reset();

      // RAM round trip, including the top address
      step(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("ram_0x10", 32'(bus.cpu_rdata), 32'hA5);
      step(32'h0001_FFFF, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      step(32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("ram_0x1ffff", 32'(bus.cpu_rdata), 32'h5A);

      // Output path: 0x41 emitted, 0x00 write ignored
      emitted.delete();
      step(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
      step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("tx_count", 32'(emitted.size()), 32'd1);
      if (emitted.size() != 0) chk("tx_41", 32'(emitted[0]), 32'h41);

      // Backpressure: 8 fills the queue, a 9th is dropped, one pop reopens it
      emitted.delete();
      for (int i = 0; i < 8; i++) step(32'h0003_0000, 1'b1, 8'(8'h11 + i), 1'b0, 8'h00, 1'b0);
      chk("full_rdy", 32'(bus.rdy_out), 32'h0);
      step(32'h0003_0000, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
      chk("full_rdy9", 32'(bus.rdy_out), 32'h0);
      idle(1'b1);
      chk("rdy_after_pop", 32'(bus.rdy_out), 32'h1);
      for (int i = 0; i < 10; i++) idle(1'b1);
      chk("drain_count", 32'(emitted.size()), 32'd8);
      for (int i = 0; i < 8 && i < emitted.size(); i++) chk("drain_order", 32'(emitted[i]), 32'(8'h11 + i));

      // Counter coherence at cycle 300, then counting while stalled
      do_reset();
      for (int i = 0; i < 300; i++) idle(1'b0);
      step(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("cyc_b0", 32'(bus.cpu_rdata), 32'h2C);
      step(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("cyc_b1", 32'(bus.cpu_rdata), 32'h01);
      for (int i = 0; i < 8; i++) step(32'h0003_0000, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 12; i++) step(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 10; i++) idle(1'b1);
      for (int i = 0; i < 4; i++) step(32'h0003_0004 + 32'(i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Input path
      step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b1);
      chk("rx_7e", 32'(bus.cpu_rdata), 32'h7E);
      chk("rx_pop_hi", 32'(bus.rx_pop), 32'h1);
      idle(1'b1);
      chk("rx_pop_once", 32'(bus.rx_pop), 32'h0);
      step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b1);
      chk("rx_empty", 32'(bus.cpu_rdata), 32'h00);

      // Randomized mix; upper address bits are noise that must not affect decode
      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 15);
         a  = (r < 8) ? 32'(r) : 32'h1FFF0 + 32'(r);
         wd = 8'($urandom);
         case ($urandom_range(0, 7))
            0: step(a, 1'b1, wd, 1'b0, 8'h00, 1'($urandom));
            1, 7: step(a, 1'b0, 8'h00, 1'($urandom), 8'($urandom), 1'($urandom));
            2: step(32'h0003_0000, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : wd, 1'b0, 8'h00, 1'($urandom));
            3: step(32'h0003_0000, 1'b0, 8'h00, 1'($urandom), 8'($urandom), 1'($urandom));
            4: step(32'h0003_0004 + 32'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b0, 8'h00, 1'($urandom));
            5: step(32'h0003_0008 + 32'($urandom_range(0, 7)), 1'b0, 8'h00, 1'b0, 8'h00, 1'($urandom));
            default: step(32'h0003_0005 + 32'($urandom_range(0, 2)), 1'b1, wd, 1'b0, 8'h00, 1'($urandom));
         endcase
         if ((n % 7) == 3) begin
            a = {14'($urandom), 18'h00010};
            step(a, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
         end
      end

      // Stop: 0x30004 emits 0x00 and latches prog_done; later I/O writes are ignored
      do_reset();
      emitted.delete();
      step(32'h0003_0004, 1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
      chk("done_set", 32'(bus.prog_done), 32'h1);
      for (int i = 0; i < 3; i++) idle(1'b1);
      step(32'h0003_0000, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
      step(32'h0003_0004, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("stop_count", 32'(emitted.size()), 32'd1);
      if (emitted.size() != 0) chk("stop_byte", 32'(emitted[0]), 32'h00);
      step(32'h0000_0020, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
      step(32'h0000_0020, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("ram_after_stop", 32'(bus.cpu_rdata), 32'hC3);

      // Reset mid-drain with a pending rx_pop; RAM survives reset
      do_reset();
      for (int i = 0; i < 4; i++) step(32'h0003_0000, 1'b1, 8'(8'hB0 + i), 1'b0, 8'h00, 1'b0);
      step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1);
      chk("pre_rst_pop", 32'(bus.rx_pop), 32'h1);
      #3 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      do_reset();
      step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("ram_survives", 32'(bus.cpu_rdata), 32'hA5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
